// File: rtl/spi_stp_receiver.sv
// ---------------------------------------------------------------------------
// spi_stp_receiver
//
// Serial-to-parallel receiver for the MRAM SPI link (read path). The SPI
// clock level and MISO line are oversampled by FPGA_clk through matched
// synchronizer chains. Bits are shifted in MSB first on each detected rising
// SPI clock edge. Completed words are presented with a valid/ack handshake
// and a sticky overrun flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | en low (or just after reset); shift register and count held at 0
// SHIFT | frame open; each rising sclk edge shifts one bit in
//
// Ports:
//   FPGA_clk     in   system clock (only clock)
//   FPGA_rst     in   asynchronous active-low reset
//   en           in   frame enable, FPGA_clk domain (not synchronized)
//   sclk         in   SPI clock level, oversampled
//   ser_data_in  in   serial data from device (MISO)
//   data_ack     in   consumer acknowledge of data_out
//   data_out     out  last completed word
//   data_valid   out  data_out holds an unacknowledged word
//   overrun      out  sticky: word completed while previous one unacknowledged
//   busy         out  at least one bit of the current word received
//   bit_index    out  bits received in the current word
// ---------------------------------------------------------------------------
module spi_stp_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          FPGA_clk,
    input  logic                          FPGA_rst,
    input  logic                          en,
    input  logic                          sclk,
    input  logic                          ser_data_in,
    input  logic                          data_ack,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_index
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_s;
    logic                   sdi_s;
    logic                   sclk_d;
    logic                   sclk_rise;

    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   bit_take;
    logic                   word_done;

    // Both lines use the same depth so data stays aligned with its clock edge.
    always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
        end else begin
            sclk_sync[0] <= sclk;
            sdi_sync[0]  <= ser_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                sdi_sync[i]  <= sdi_sync[i-1];
            end
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // sclk_d tracks sclk_s unconditionally, so a level that is already high
    // when the frame opens is never mistaken for an edge.
    always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;

    always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = SHIFT;
            SHIFT:   if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Dropping en in SHIFT aborts the frame; abort takes priority over an edge.
    assign bit_take  = (state == SHIFT) && en && sclk_rise;
    assign word_done = bit_take && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign shift_nxt = {shift_reg[DATA_WIDTH-2:0], sdi_s};

    always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if ((state != SHIFT) || !en) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bit_take) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Handshake runs independently of frame state so a pending word can be
    // acknowledged during or after an abort.
    always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done) begin
                data_out   <= shift_nxt;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end

            // Completion together with ack consumes the old word cleanly and
            // leaves overrun as it was.
            if (word_done && data_valid && !data_ack) begin
                overrun <= 1'b1;
            end else if (data_ack && !word_done) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy      = (state == SHIFT) && (bit_cnt != '0);
    assign bit_index = bit_cnt;

endmodule

// File: tb/tb_spi_stp_receiver.sv
module tb_spi_stp_receiver;

    logic        FPGA_clk;
    logic        FPGA_rst;
    logic        en;
    logic        sclk;
    logic        ser_data_in;
    logic        data_ack;
    logic [15:0] data_out;
    logic        data_valid;
    logic        overrun;
    logic        busy;
    logic [3:0]  bit_index;

    int n_vec;
    int n_err;
    int valid_rises;
    int rises_mark;
    logic valid_q;

    spi_stp_receiver #(
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .FPGA_clk    (FPGA_clk),
        .FPGA_rst    (FPGA_rst),
        .en          (en),
        .sclk        (sclk),
        .ser_data_in (ser_data_in),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .overrun     (overrun),
        .busy        (busy),
        .bit_index   (bit_index)
    );

    initial FPGA_clk = 1'b0;
    always #5 FPGA_clk = ~FPGA_clk;

    // Counts data_valid assertions (0 -> 1 transitions), sampled off-edge.
    initial begin
        valid_rises = 0;
        valid_q     = 1'b0;
    end
    always @(negedge FPGA_clk) begin
        if (data_valid && !valid_q) valid_rises++;
        valid_q = data_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One bit with an 8-cycle sclk period: 4 low, 4 high. Data changes while
    // sclk is low and is held through the high phase.
    task automatic send_bit(input logic b);
        ser_data_in = b;
        sclk        = 1'b0;
        repeat (4) @(negedge FPGA_clk);
        sclk = 1'b1;
        repeat (4) @(negedge FPGA_clk);
    endtask

    task automatic send_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[15-i]);
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        @(negedge FPGA_clk);
        data_ack = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        FPGA_rst    = 1'b0;
        en          = 1'b0;
        sclk        = 1'b0;
        ser_data_in = 1'b0;
        data_ack    = 1'b0;
        repeat (3) @(negedge FPGA_clk);

        chk("rst_data_out",   32'(data_out),   32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_bit_index",  32'(bit_index),  32'h0);

        FPGA_rst = 1'b1;
        repeat (2) @(negedge FPGA_clk);

        // Basic word 0xA5C3 with exact latency on the final bit.
        en = 1'b1;
        @(negedge FPGA_clk);
        send_word(16'hA5C3, 15);
        chk("basic_bit_index15", 32'(bit_index), 32'd15);
        ser_data_in = 1'b1;
        sclk        = 1'b0;
        repeat (4) @(negedge FPGA_clk);
        sclk = 1'b1;
        @(negedge FPGA_clk);
        chk("basic_valid_edge1", 32'(data_valid), 32'h0);
        @(negedge FPGA_clk);
        chk("basic_valid_edge2", 32'(data_valid), 32'h0);
        chk("basic_busy_edge2",  32'(busy),       32'h1);
        @(negedge FPGA_clk);
        chk("basic_valid_edge3", 32'(data_valid), 32'h1);
        chk("basic_data_edge3",  32'(data_out),   32'hA5C3);
        chk("basic_busy_edge3",  32'(busy),       32'h0);
        @(negedge FPGA_clk);
        pulse_ack();
        chk("basic_ack_valid", 32'(data_valid), 32'h0);
        chk("basic_ack_data",  32'(data_out),   32'hA5C3);

        // Abort after 7 bits, then a clean 0x1234.
        rises_mark = valid_rises;
        send_word(16'hFFFF, 7);
        chk("abort_bit_index7", 32'(bit_index), 32'd7);
        en = 1'b0;
        @(negedge FPGA_clk);
        chk("abort_bit_index", 32'(bit_index), 32'h0);
        chk("abort_busy",      32'(busy),      32'h0);
        chk("abort_valid",     32'(data_valid), 32'h0);
        en = 1'b1;
        @(negedge FPGA_clk);
        send_word(16'h1234, 16);
        chk("abort_data",        32'(data_out),   32'h1234);
        chk("abort_valid_after", 32'(data_valid), 32'h1);
        chk("abort_valid_count", 32'(valid_rises - rises_mark), 32'd1);
        pulse_ack();

        // Overrun: two words back-to-back without ack.
        send_word(16'hFFFF, 16);
        chk("ovr_first_overrun", 32'(overrun), 32'h0);
        send_word(16'h0001, 16);
        chk("ovr_data",    32'(data_out),   32'h0001);
        chk("ovr_valid",   32'(data_valid), 32'h1);
        chk("ovr_overrun", 32'(overrun),    32'h1);
        pulse_ack();
        chk("ovr_ack_valid",   32'(data_valid), 32'h0);
        chk("ovr_ack_overrun", 32'(overrun),    32'h0);

        // Ack on the same edge the second word completes.
        send_word(16'h1111, 16);
        chk("simul_first_valid", 32'(data_valid), 32'h1);
        send_word(16'h8001, 15);
        ser_data_in = 1'b1;
        sclk        = 1'b0;
        repeat (4) @(negedge FPGA_clk);
        sclk = 1'b1;
        repeat (2) @(negedge FPGA_clk);
        data_ack = 1'b1;
        @(negedge FPGA_clk);
        data_ack = 1'b0;
        chk("simul_data",    32'(data_out),   32'h8001);
        chk("simul_valid",   32'(data_valid), 32'h1);
        chk("simul_overrun", 32'(overrun),    32'h0);
        @(negedge FPGA_clk);
        pulse_ack();

        // sclk already high when en rises must not count as a bit.
        en = 1'b0;
        @(negedge FPGA_clk);
        sclk = 1'b1;
        repeat (4) @(negedge FPGA_clk);
        en = 1'b1;
        repeat (4) @(negedge FPGA_clk);
        chk("prehigh_bit_index0", 32'(bit_index), 32'h0);
        send_word(16'h00FF, 16);
        chk("prehigh_data",      32'(data_out),   32'h00FF);
        chk("prehigh_valid",     32'(data_valid), 32'h1);
        chk("prehigh_bit_index", 32'(bit_index),  32'h0);
        chk("prehigh_overrun",   32'(overrun),    32'h0);

        // Reset mid-frame with a word still pending.
        send_word(16'hFFFF, 9);
        chk("rstmid_bit_index9", 32'(bit_index), 32'd9);
        FPGA_rst = 1'b0;
        #1;
        chk("rstmid_data_out",   32'(data_out),   32'h0);
        chk("rstmid_data_valid", 32'(data_valid), 32'h0);
        chk("rstmid_overrun",    32'(overrun),    32'h0);
        chk("rstmid_busy",       32'(busy),       32'h0);
        chk("rstmid_bit_index",  32'(bit_index),  32'h0);
        en   = 1'b0;
        sclk = 1'b0;
        repeat (3) @(negedge FPGA_clk);
        FPGA_rst = 1'b1;
        repeat (2) @(negedge FPGA_clk);
        en = 1'b1;
        @(negedge FPGA_clk);
        send_word(16'h5A5A, 16);
        chk("rstmid_after_data",  32'(data_out),   32'h5A5A);
        chk("rstmid_after_valid", 32'(data_valid), 32'h1);
        chk("rstmid_after_ovr",   32'(overrun),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_stp_receiver.md
# spi_stp_receiver

Serial-to-parallel receiver for the MRAM SPI link. It samples the serial data line on each rising SPI clock edge, MSB first, and assembles `DATA_WIDTH`-bit words. It presents each completed word with a valid/acknowledge handshake and an overrun flag. It is the read-path counterpart of the parallel-to-serial transmitter and sits between the SPI pins and the controller FSM.

## Interface
- `DATA_WIDTH`, 16: word length in bits, shifted MSB first.
- `SYNC_STAGES`, 2: flop stages on `sclk` and `ser_data_in`, minimum 1. Both lines use the same depth so they stay aligned.
- `FPGA_clk` in 1: system clock. The only clock.
- `FPGA_rst` in 1: reset, asynchronous, active-low.
- `en` in 1: frame enable (chip-select equivalent). While 0, the receiver is held idle.
- `sclk` in 1: SPI clock level as driven to the device. It is oversampled by `FPGA_clk`.
- `ser_data_in` in 1: serial data from the device (MISO).
- `data_ack` in 1: consumer acknowledge of `data_out`.
- `data_out` out `DATA_WIDTH`: last completed word.
- `data_valid` out 1: `data_out` holds an unacknowledged word.
- `overrun` out 1: sticky. A word completed while the previous one was still unacknowledged.
- `busy` out 1: at least one bit of the current word has been received.
- `bit_index` out `$clog2(DATA_WIDTH)`: count of bits received in the current word (0..`DATA_WIDTH`-1).

## Operation
- Reset values:
  - `data_out`=0, `data_valid`=0, `overrun`=0, `busy`=0, `bit_index`=0.
  - Shift register = 0, state IDLE, synchronizer flops and edge-detect flop = 0.
- Synchronization and edge detection:
  - `sclk` and `ser_data_in` each pass through `SYNC_STAGES` flops, giving `sclk_s` and `sdi_s`.
  - `sclk_d` registers `sclk_s` every cycle, regardless of `en` or state.
  - A rising edge is `sclk_s & ~sclk_d`.
- States:
  - IDLE -> SHIFT when `en`=1.
  - SHIFT -> IDLE when `en`=0. This aborts the frame: the shift register and bit count clear, partial bits are discarded, `data_out`, `data_valid` and `overrun` are unchanged, and no `data_valid` is produced.
- In SHIFT, on each rising edge:
  - `shift <= {shift[DATA_WIDTH-2:0], sdi_s}`.
  - The bit count increments.
- On the `DATA_WIDTH`-th edge:
  - `data_out <= {shift[DATA_WIDTH-2:0], sdi_s}`.
  - `data_valid <= 1`.
  - The bit count wraps to 0.
  - The state stays SHIFT, so back-to-back words need no `en` toggle.
- Handshake:
  - `data_valid` stays high until `data_ack` is sampled high, then clears on the next edge.
  - `data_ack` while `data_valid`=0 has no effect on `data_valid`.
- Overrun:
  - A word that completes while `data_valid`=1 and `data_ack`=0 overwrites `data_out` and sets `overrun`.
  - `overrun` clears only on reset, or on an edge where `data_ack`=1 and no word completes.
- Word completion coinciding with `data_ack`=1: the old word is consumed, the new word is loaded, `data_valid` stays 1, and `overrun` is not set.
- If `sclk_s` is already 1 when `en` rises, that level is not an edge. Only a later 0->1 transition counts.
- Edges detected in IDLE are ignored.
- `busy` = (state==SHIFT) && (bit count != 0).
- `bit_index` = bit count.

## Timing
- Latency from a raw `sclk` rise (set up to `FPGA_clk`) to that bit entering the shift register is `SYNC_STAGES`+1 `FPGA_clk` edges. The final bit reaches `data_valid`=1 with the same latency.
- `ser_data_in` must be stable for at least `SYNC_STAGES`+1 `FPGA_clk` cycles around each `sclk` rise.
- `sclk` high and low phases must each be at least 2 `FPGA_clk` cycles. Faster `sclk` is unsupported.
- `en` takes effect on the next `FPGA_clk` edge. `en` is not synchronized, because the controller drives it in the `FPGA_clk` domain.
- Asserting `FPGA_rst` mid-frame immediately forces all reset values. After release, the first word requires a fresh `en`=1 and `DATA_WIDTH` edges.

## Test plan
- Basic word: `en`=1, shift in 0xA5C3 MSB first with an 8-cycle `sclk` period. Required: `data_out`=0xA5C3 and `data_valid`=1, exactly 3 edges after the 16th raw `sclk` rise; `busy` falls on the same edge.
- Abort: shift 7 bits of 0xFFFF, drop `en` for 1 cycle, raise it, then shift 0x1234. Required: only 0x1234 appears, with one `data_valid` assertion, and `bit_index` reads 0 after the abort.
- Overrun: shift 0xFFFF then 0x0001 back-to-back with `data_ack`=0. Required: `data_out`=0x0001, `data_valid`=1, `overrun`=1. Then pulse `data_ack`. Required: `data_valid`=0 and `overrun`=0.
- Simultaneous completion and ack: pulse `data_ack` on the same edge the second word 0x8001 completes. Required: `data_out`=0x8001, `data_valid`=1, `overrun`=0.
- Pre-high `sclk`: hold `sclk`=1 while raising `en`, then send 16 clean edges of 0x00FF. Required: `data_out`=0x00FF, with no extra bit counted.
- Reset mid-frame: assert `FPGA_rst` after 9 bits. Required: all outputs are 0 asynchronously. After release, a full 0x5A5A is received correctly.
